// File: rtl/counter_pkg.sv
// Shared types and constants for the modulo-counter reload controller.
package counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } cnt_reload_state_t;

   localparam int CNT_WIDTH_DEFAULT = 4;

   // Truncated to the counter width at use: start resets to 0, end to all ones.
   localparam logic [31:0] CNT_START_RST = '0;
   localparam logic [31:0] CNT_END_RST   = '1;

endpackage

// File: rtl/cfg_shadow_reg.sv
// Pending-configuration holding register with its ready logic.
// Only built with CNT_RELOAD_SHADOW_EN defined.
`ifdef CNT_RELOAD_SHADOW_EN
module cfg_shadow_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_idle,
   input  logic             cfg_hs,
   input  logic [WIDTH-1:0] cfg_start,
   input  logic [WIDTH-1:0] cfg_end,
   input  logic             consume,
   output logic             pend_v,
   output logic [WIDTH-1:0] pend_start,
   output logic [WIDTH-1:0] pend_end,
   output logic             cfg_ready
);

   // Handshakes in IDLE write the active config directly; only the others land here.
   logic wr;
   assign wr        = cfg_hs && !in_idle;
   assign cfg_ready = in_idle || !pend_v;

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_v     <= 1'b0;
         pend_start <= '0;
         pend_end   <= '0;
      end else if (wr) begin
         pend_v     <= 1'b1;
         pend_start <= cfg_start;
         pend_end   <= cfg_end;
      end else if (consume) begin
         pend_v     <= 1'b0;
      end
   end

endmodule
`endif

// File: rtl/counter_reload_ctrl.sv
// Drives load/load_data on a loadable counter to make it a start..end modulo counter.
// Optional RUN-time reconfiguration via pending register: CNT_RELOAD_SHADOW_EN.
module counter_reload_ctrl
   import counter_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_start,
   input  logic [WIDTH-1:0] cfg_end,
   input  logic [WIDTH-1:0] count,
   output logic             load,
   output logic [WIDTH-1:0] load_data,
   output logic             wrap
);

   cnt_reload_state_t state, state_nxt;
   logic [WIDTH-1:0]  start_q, end_q;
   logic              pend_v;
   logic [WIDTH-1:0]  pend_start, pend_end;
   logic              cfg_hs, in_idle, run_reload, take_pend;

   assign in_idle    = (state == IDLE);
   assign cfg_hs     = cfg_valid && cfg_ready;
   assign run_reload = (state == RUN) && enable && (count == end_q);
   assign take_pend  = pend_v && (in_idle || run_reload);

`ifdef CNT_RELOAD_SHADOW_EN
   cfg_shadow_reg #(.WIDTH(WIDTH)) u_shadow (
      .clk        (clk),
      .reset      (reset),
      .in_idle    (in_idle),
      .cfg_hs     (cfg_hs),
      .cfg_start  (cfg_start),
      .cfg_end    (cfg_end),
      .consume    (take_pend),
      .pend_v     (pend_v),
      .pend_start (pend_start),
      .pend_end   (pend_end),
      .cfg_ready  (cfg_ready)
   );
`else
   assign pend_v     = 1'b0;
   assign pend_start = '0;
   assign pend_end   = '0;
   assign cfg_ready  = in_idle;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // A fresh IDLE handshake is newer than anything still pending, so it wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         start_q <= WIDTH'(CNT_START_RST);
         end_q   <= WIDTH'(CNT_END_RST);
      end else if (cfg_hs && in_idle) begin
         start_q <= cfg_start;
         end_q   <= cfg_end;
      end else if (take_pend) begin
         start_q <= pend_start;
         end_q   <= pend_end;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      load_data = '0;
      wrap      = 1'b0;
      case (state)
         IDLE: if (enable) state_nxt = ARM;
         ARM: begin
            load      = 1'b1;
            load_data = start_q;
            state_nxt = RUN;
         end
         RUN: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (count == end_q) begin
               load      = 1'b1;
               wrap      = 1'b1;
               load_data = pend_v ? pend_start : start_q;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
